// File: rtl/prog_seq_ctrl.sv
// -----------------------------------------------------------------------------
// prog_seq_ctrl
//
// Program-counter sequencer. Owns the PC and addresses the branch-target
// lookup table. Handles the start/done handshake with the harness, absolute
// and relative branches, and a shallow call/return stack. A stack overflow or
// underflow sets a sticky error flag and ends the program.
//
// Ports
//   clk_i         clock
//   reset_i       synchronous, active-high reset
//   start_i       begin program (level, sampled in IDLE)
//   start_idx_i   LUT index holding the program entry point
//   halt_i        current instruction ends the program
//   stall_i       hold PC this cycle
//   br_abs_i      taken absolute branch to LUT[br_idx_i]
//   br_rel_i      taken relative branch, PC + rel_off_i
//   call_i        push return address, jump to LUT[br_idx_i]
//   ret_i         pop return address into PC
//   br_idx_i      LUT index for br_abs_i / call_i
//   rel_off_i     signed two's-complement relative offset
//   lut_addr_o    LUT index: start_idx_i in IDLE, else br_idx_i
//   lut_target_i  LUT data (combinational response to lut_addr_o)
//   pc_o          current program counter
//   busy_o        high in RUN
//   done_o        high in DONE
//   err_o         sticky stack over/underflow flag
// -----------------------------------------------------------------------------
module prog_seq_ctrl #(
  parameter int D  = 12,
  parameter int AW = 5,
  parameter int OW = 8,
  parameter int SD = 4
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [AW-1:0] start_idx_i,
  input  logic          halt_i,
  input  logic          stall_i,
  input  logic          br_abs_i,
  input  logic          br_rel_i,
  input  logic          call_i,
  input  logic          ret_i,
  input  logic [AW-1:0] br_idx_i,
  input  logic [OW-1:0] rel_off_i,
  output logic [AW-1:0] lut_addr_o,
  input  logic [D-1:0]  lut_target_i,
  output logic [D-1:0]  pc_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  // Stack pointer must represent 0..SD inclusive (SD means full).
  localparam int SPW = $clog2(SD + 1);
  localparam int SIW = (SD > 1) ? $clog2(SD) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic           push_en;
  logic [D-1:0]   stack_q [SD];

  logic [D-1:0]   pc_inc;
  logic [D-1:0]   rel_ext;
  logic [SIW-1:0] wr_idx;
  logic [SIW-1:0] rd_idx;

  assign pc_inc  = pc_q + D'(1);
  assign rel_ext = {{(D-OW){rel_off_i[OW-1]}}, rel_off_i};
  assign wr_idx  = SIW'(sp_q);
  assign rd_idx  = SIW'(sp_q - SPW'(1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  // NOTE: stack storage has no reset; entries are only read below sp_q, so
  // stale contents are never observed, and leaving them unreset lets the
  // array map onto plain flops or a register file.
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      stack_q[wr_idx] <= pc_inc;
    end
  end

  // Next-state logic. One RUN action per cycle, resolved by priority.
  // NOTE: every signal gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          pc_d    = lut_target_i;
          err_d   = 1'b0;
          sp_d    = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (halt_i) begin
          state_d = ST_DONE;
        end else if (stall_i) begin
          // hold everything
        end else if (call_i) begin
          if (sp_q == SPW'(SD)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + SPW'(1);
            pc_d    = lut_target_i;
          end
        end else if (ret_i) begin
          if (sp_q == '0) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            pc_d = stack_q[rd_idx];
            sp_d = sp_q - SPW'(1);
          end
        end else if (br_abs_i) begin
          pc_d = lut_target_i;
        end else if (br_rel_i) begin
          pc_d = pc_q + rel_ext;  // wraps silently mod 2^D
        end else begin
          pc_d = pc_inc;
        end
      end

      ST_DONE: begin
        // A held-high Start keeps us here so a level cannot retrigger a run.
        if (!start_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: decodes of registered state plus the LUT address mux.
  always_comb begin
    busy_o     = (state_q == ST_RUN);
    done_o     = (state_q == ST_DONE);
    lut_addr_o = (state_q == ST_IDLE) ? start_idx_i : br_idx_i;
  end

  assign pc_o  = pc_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_prog_seq_ctrl.sv
module tb_prog_seq_ctrl;

  localparam int D  = 12;
  localparam int AW = 5;
  localparam int OW = 8;
  localparam int SD = 4;
  localparam int PC_MASK = (1 << D) - 1;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          start_i;
  logic [AW-1:0] start_idx_i;
  logic          halt_i;
  logic          stall_i;
  logic          br_abs_i;
  logic          br_rel_i;
  logic          call_i;
  logic          ret_i;
  logic [AW-1:0] br_idx_i;
  logic [OW-1:0] rel_off_i;
  logic [AW-1:0] lut_addr_o;
  logic [D-1:0]  lut_target_i;
  logic [D-1:0]  pc_o;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  always #5 clk_i = ~clk_i;

  // Lookup table model, answered combinationally.
  logic [D-1:0] lut [1 << AW];
  assign lut_target_i = lut[lut_addr_o];

  prog_seq_ctrl #(.D(D), .AW(AW), .OW(OW), .SD(SD)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .start_idx_i  (start_idx_i),
    .halt_i       (halt_i),
    .stall_i      (stall_i),
    .br_abs_i     (br_abs_i),
    .br_rel_i     (br_rel_i),
    .call_i       (call_i),
    .ret_i        (ret_i),
    .br_idx_i     (br_idx_i),
    .rel_off_i    (rel_off_i),
    .lut_addr_o   (lut_addr_o),
    .lut_target_i (lut_target_i),
    .pc_o         (pc_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural reference: a mode name, an integer PC and a queue for the stack.
  typedef enum {M_IDLE, M_RUN, M_DONE} mode_e;
  mode_e m_mode = M_IDLE;
  int    m_pc   = 0;
  bit    m_err  = 1'b0;
  int    m_stack[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int o;
    if (reset_i) begin
      m_pc = 0; m_mode = M_IDLE; m_err = 1'b0; m_stack.delete();
    end else begin
      case (m_mode)
        M_IDLE: if (start_i) begin
          m_pc = int'(lut[start_idx_i]); m_err = 1'b0; m_stack.delete(); m_mode = M_RUN;
        end
        M_DONE: if (!start_i) m_mode = M_IDLE;
        default: begin
          if (halt_i) m_mode = M_DONE;
          else if (stall_i) begin end
          else if (call_i) begin
            if (m_stack.size() >= SD) begin m_err = 1'b1; m_mode = M_DONE; end
            else begin m_stack.push_back((m_pc + 1) & PC_MASK); m_pc = int'(lut[br_idx_i]); end
          end else if (ret_i) begin
            if (m_stack.size() == 0) begin m_err = 1'b1; m_mode = M_DONE; end
            else m_pc = m_stack.pop_back();
          end else if (br_abs_i) m_pc = int'(lut[br_idx_i]);
          else if (br_rel_i) begin
            o = int'(rel_off_i);
            if (o >= (1 << (OW - 1))) o -= (1 << OW);
            m_pc = (m_pc + o) & PC_MASK;
          end else m_pc = (m_pc + 1) & PC_MASK;
        end
      endcase
    end
  endtask

  task automatic clear_ctrl();
    halt_i = 0; stall_i = 0; br_abs_i = 0; br_rel_i = 0; call_i = 0; ret_i = 0;
  endtask

  // Inputs are already set; advance one clock and compare against the model.
  task automatic cycle(input string tag);
    #1;
    check({tag, ".lut_addr"}, 32'(lut_addr_o), (m_mode == M_IDLE) ? 32'(start_idx_i) : 32'(br_idx_i));
    model_step();
    @(posedge clk_i);
    #1;
    check({tag, ".pc"},   32'(pc_o),   32'(m_pc));
    check({tag, ".busy"}, 32'(busy_o), 32'(m_mode == M_RUN));
    check({tag, ".done"}, 32'(done_o), 32'(m_mode == M_DONE));
    check({tag, ".err"},  32'(err_o),  32'(m_err));
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) lut[i] = D'((i * 97 + 13) % (1 << D));
    lut[0] = 0; lut[3] = 29; lut[9] = 120; lut[16] = 211;
    lut[1] = 40; lut[2] = 50; lut[4] = 150;

    reset_i = 1; start_i = 0; start_idx_i = 0; br_idx_i = 0; rel_off_i = 0;
    clear_ctrl();
    cycle("reset0");
    cycle("reset1");
    check("reset_pc", 32'(pc_o), 0);
    reset_i = 0;

    // Start from LUT[3], then free-run five increments.
    start_i = 1; start_idx_i = 3;
    cycle("start3");
    check("start3_pc_const", 32'(pc_o), 29);
    start_i = 0;
    for (int i = 0; i < 5; i++) cycle("incr");
    check("incr5_pc_const", 32'(pc_o), 34);

    // Relative branches including wrap below zero.
    br_abs_i = 1; br_idx_i = 9; cycle("brabs9"); clear_ctrl();
    br_rel_i = 1; rel_off_i = 8'hF6; cycle("brrel_m10");
    check("brrel_m10_const", 32'(pc_o), 110);
    rel_off_i = 8'h7F; cycle("brrel_p127");
    check("brrel_p127_const", 32'(pc_o), 237);
    clear_ctrl(); br_abs_i = 1; br_idx_i = 0; cycle("brabs0"); clear_ctrl();
    br_rel_i = 1; rel_off_i = 8'hFF; cycle("brrel_wrap");
    check("brrel_wrap_const", 32'(pc_o), 4095);
    clear_ctrl(); cycle("incr_wrap");
    check("incr_wrap_const", 32'(pc_o), 0);

    // Call / return.
    br_abs_i = 1; br_idx_i = 2; cycle("brabs2"); clear_ctrl();
    call_i = 1; br_idx_i = 16; cycle("call16"); clear_ctrl();
    check("call16_const", 32'(pc_o), 211);
    cycle("incr_a"); cycle("incr_b");
    ret_i = 1; cycle("ret"); clear_ctrl();
    check("ret_const", 32'(pc_o), 51);

    // Overflow on the fifth nested call.
    call_i = 1; br_idx_i = 9;
    for (int i = 0; i < 5; i++) cycle("nest_call");
    clear_ctrl();
    check("overflow_err", 32'(err_o), 1);
    check("overflow_done", 32'(done_o), 1);
    cycle("done_to_idle");
    start_i = 1; start_idx_i = 3; cycle("restart_clears_err"); start_i = 0;
    check("restart_err_const", 32'(err_o), 0);
    ret_i = 1; cycle("underflow"); clear_ctrl();
    check("underflow_err", 32'(err_o), 1);
    cycle("done_to_idle2");

    // Halt beats Stall and BrAbs; Start held keeps DONE.
    start_i = 1; start_idx_i = 1; cycle("start40");
    halt_i = 1; stall_i = 1; br_abs_i = 1; br_idx_i = 9; cycle("halt_prio"); clear_ctrl();
    check("halt_prio_pc", 32'(pc_o), 40);
    for (int i = 0; i < 3; i++) cycle("start_held");
    check("start_held_done", 32'(done_o), 1);
    start_i = 0; cycle("start_drop");
    check("start_drop_done", 32'(done_o), 0);

    // Reset mid-run with two frames on the stack.
    start_i = 1; start_idx_i = 4; cycle("start150"); start_i = 0;
    call_i = 1; br_idx_i = 4; cycle("call_a"); cycle("call_b"); clear_ctrl();
    reset_i = 1; cycle("midrun_reset"); reset_i = 0;
    check("midrun_reset_pc", 32'(pc_o), 0);
    start_i = 1; start_idx_i = 0; cycle("start0"); start_i = 0;
    ret_i = 1; cycle("ret_after_reset"); clear_ctrl();
    check("stack_emptied_by_reset", 32'(err_o), 1);

    // Randomized phase.
    for (int n = 0; n < 600; n++) begin
      reset_i     = ($urandom_range(0, 99) == 0);
      start_i     = ($urandom_range(0, 2) == 0);
      start_idx_i = AW'($urandom);
      halt_i      = ($urandom_range(0, 24) == 0);
      stall_i     = ($urandom_range(0, 7) == 0);
      call_i      = ($urandom_range(0, 4) == 0);
      ret_i       = ($urandom_range(0, 4) == 0);
      br_abs_i    = ($urandom_range(0, 5) == 0);
      br_rel_i    = ($urandom_range(0, 3) == 0);
      br_idx_i    = AW'($urandom);
      rel_off_i   = OW'($urandom);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
